// File: rtl/axi4lite_wb_bridge_if.sv
// Bus bundle for axi4lite_wb_bridge.
// Carries the AXI4-Lite slave channels (AW, W, B, AR, R) and the Wishbone
// classic master signals. Signal suffixes (_i/_o) are named from the bridge's
// point of view.
//   slave  : bridge side (AXI4-Lite slave, Wishbone master)
//   master : environment side (AXI4-Lite master, Wishbone slave)
interface axi4lite_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   axi_awaddr_i;
  logic                    axi_awvalid_i;
  logic                    axi_awready_o;
  logic [DATA_WIDTH-1:0]   axi_wdata_i;
  logic [DATA_WIDTH/8-1:0] axi_wstrb_i;
  logic                    axi_wvalid_i;
  logic                    axi_wready_o;
  logic [1:0]              axi_bresp_o;
  logic                    axi_bvalid_o;
  logic                    axi_bready_i;
  logic [ADDR_WIDTH-1:0]   axi_araddr_i;
  logic                    axi_arvalid_i;
  logic                    axi_arready_o;
  logic [DATA_WIDTH-1:0]   axi_rdata_o;
  logic [1:0]              axi_rresp_o;
  logic                    axi_rvalid_o;
  logic                    axi_rready_i;

  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic                    wb_we_o;
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    wb_rty_i;

  modport slave (
    input  axi_awaddr_i, axi_awvalid_i, axi_wdata_i, axi_wstrb_i, axi_wvalid_i,
           axi_bready_i, axi_araddr_i, axi_arvalid_i, axi_rready_i,
           wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output axi_awready_o, axi_wready_o, axi_bresp_o, axi_bvalid_o,
           axi_arready_o, axi_rdata_o, axi_rresp_o, axi_rvalid_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport master (
    output axi_awaddr_i, axi_awvalid_i, axi_wdata_i, axi_wstrb_i, axi_wvalid_i,
           axi_bready_i, axi_araddr_i, axi_arvalid_i, axi_rready_i,
           wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  axi_awready_o, axi_wready_o, axi_bresp_o, axi_bvalid_o,
           axi_arready_o, axi_rdata_o, axi_rresp_o, axi_rvalid_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/axi4lite_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge.
// One-entry holding registers for AW, W and AR let AW/W arrive in any order
// and let the next request be accepted while a Wishbone cycle is running.
// Only one Wishbone transaction is outstanding; read/write launches alternate
// when both are ready. Wishbone ack/err/rty and a stb timeout are mapped onto
// OKAY/SLVERR/DECERR.
// Ports:
//   clk_i      single clock for both buses
//   axi_rst_i  asynchronous active-low reset
//   wb_rst_o   active-high reset to the Wishbone side (~axi_rst_i)
//   bus        AXI4-Lite slave channels + Wishbone master signals
module axi4lite_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic                 clk_i,
  input  logic                 axi_rst_i,
  output logic                 wb_rst_o,
  axi4lite_wb_bridge_if.slave  bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ~ADDR_WIDTH'(SW - 1);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WB_WRITE, WB_READ, RETRY_GAP, WRESP, RRESP} state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;      // 0: write goes first, 1: read goes first
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [SW-1:0]         w_strb_q, w_strb_d;
  logic                  ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  fin;
  logic [1:0]            fin_resp;
  logic                  wr_rdy, rd_rdy;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    fin       = 1'b0;
    fin_resp  = OKAY;
    wr_rdy    = aw_full_q & w_full_q;
    rd_rdy    = ar_full_q;

    // Holding register loads; ready is ~full so a load never collides with
    // the launch that frees the same entry.
    if (bus.axi_awvalid_i && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = bus.axi_awaddr_i;
    end
    if (bus.axi_wvalid_i && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = bus.axi_wdata_i;
      w_strb_d = bus.axi_wstrb_i;
    end
    if (bus.axi_arvalid_i && !ar_full_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = bus.axi_araddr_i;
    end

    case (state_q)
      IDLE: begin
        if (wr_rdy && (!rd_rdy || !prio_q)) begin
          adr_d     = aw_addr_q & ADR_MASK;
          dat_d     = w_data_q;
          sel_d     = w_strb_q;
          we_d      = 1'b1;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          prio_d    = 1'b1;          // favour the side not served last
          retry_d   = '0;
          tmo_d     = '0;
          state_d   = WB_WRITE;
        end else if (rd_rdy) begin
          adr_d     = ar_addr_q & ADR_MASK;
          sel_d     = '1;
          we_d      = 1'b0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          ar_full_d = 1'b0;
          prio_d    = 1'b0;
          retry_d   = '0;
          tmo_d     = '0;
          state_d   = WB_READ;
        end
      end
      WB_WRITE, WB_READ: begin
        if (bus.wb_ack_i) begin
          fin = 1'b1;
          fin_resp = OKAY;
        end else if (bus.wb_err_i) begin
          fin = 1'b1;
          fin_resp = SLVERR;
        end else if (bus.wb_rty_i) begin
          if (retry_q != RETRY_MAX) begin
            // One idle cycle, then re-issue the same request.
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            retry_d = retry_q + 1'b1;
            tmo_d   = '0;
            state_d = RETRY_GAP;
          end else begin
            fin = 1'b1;
            fin_resp = SLVERR;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
          fin = 1'b1;
          fin_resp = DECERR;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RETRY_GAP: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        state_d = we_q ? WB_WRITE : WB_READ;
      end
      WRESP: begin
        if (bus.axi_bready_i) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RRESP: begin
        if (bus.axi_rready_i) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Common termination of a Wishbone cycle.
    if (fin) begin
      cyc_d  = 1'b0;
      stb_d  = 1'b0;
      we_d   = 1'b0;
      resp_d = fin_resp;
      if (we_q) begin
        bvalid_d = 1'b1;
        state_d  = WRESP;
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = (fin_resp == OKAY) ? bus.wb_dat_i : '0;
        state_d  = RRESP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge axi_rst_i) begin
    if (!axi_rst_i) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      resp_q    <= OKAY;
      rdata_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      retry_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
    end
  end

  assign wb_rst_o          = ~axi_rst_i;
  assign bus.axi_awready_o = ~aw_full_q;
  assign bus.axi_wready_o  = ~w_full_q;
  assign bus.axi_arready_o = ~ar_full_q;
  assign bus.axi_bvalid_o  = bvalid_q;
  assign bus.axi_bresp_o   = resp_q;
  assign bus.axi_rvalid_o  = rvalid_q;
  assign bus.axi_rresp_o   = resp_q;
  assign bus.axi_rdata_o   = rdata_q;
  assign bus.wb_adr_o      = adr_q;
  assign bus.wb_dat_o      = dat_q;
  assign bus.wb_sel_o      = sel_q;
  assign bus.wb_we_o       = we_q;
  assign bus.wb_cyc_o      = cyc_q;
  assign bus.wb_stb_o      = stb_q;
endmodule

// File: tb/tb_axi4lite_wb_bridge.sv
// Directed bench for axi4lite_wb_bridge (TIMEOUT_CYCLES=8, MAX_RETRY=3).
// A small Wishbone slave model answers on the falling edge with a
// configurable number of wait states, rty responses and final termination.
module tb_axi4lite_wb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic wb_rst;
  int   n_chk = 0;
  int   n_fail = 0;

  axi4lite_wb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  axi4lite_wb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8), .MAX_RETRY(3)
  ) dut (
    .clk_i(clk), .axi_rst_i(rst_n), .wb_rst_o(wb_rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Wishbone slave model: sl_final 0=ack, 1=err, 2=never answer.
  int          sl_wait = 0;
  int          sl_rty_n = 0;
  int          sl_final = 0;
  logic [31:0] sl_rdata = 32'h0;
  int          wcnt = 0;
  int          rty_done = 0;
  int          pulses = 0;
  logic        stb_prev = 1'b0;

  always @(negedge clk) begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    if (!rst_n) begin
      wcnt = 0;
      rty_done = 0;
    end else if (bus.axi_bvalid_o || bus.axi_rvalid_o) begin
      rty_done = 0;
    end
    if (rst_n && bus.wb_cyc_o && bus.wb_stb_o) begin
      if (!stb_prev) pulses++;
      if (wcnt < sl_wait) wcnt++;
      else begin
        wcnt = 0;
        if (rty_done < sl_rty_n) begin
          bus.wb_rty_i = 1'b1;
          rty_done++;
        end else if (sl_final == 0) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_dat_i = sl_rdata;
        end else if (sl_final == 1) begin
          bus.wb_err_i = 1'b1;
        end
      end
    end else begin
      wcnt = 0;
    end
    stb_prev = rst_n && bus.wb_cyc_o && bus.wb_stb_o;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tk();
    rst_n = 1'b1;
    tk();
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    chk("wr_ready", 64'(bus.axi_awready_o & bus.axi_wready_o), 64'h1);
    bus.axi_awaddr_i = a;
    bus.axi_wdata_i = d;
    bus.axi_wstrb_i = s;
    bus.axi_awvalid_i = 1'b1;
    bus.axi_wvalid_i = 1'b1;
    tk();
    bus.axi_awvalid_i = 1'b0;
    bus.axi_wvalid_i = 1'b0;
  endtask

  task automatic issue_rd(input logic [31:0] a);
    chk("rd_ready", 64'(bus.axi_arready_o), 64'h1);
    bus.axi_araddr_i = a;
    bus.axi_arvalid_i = 1'b1;
    tk();
    bus.axi_arvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          p0;
    logic [7:0]  h;
    logic [3:0]  ord_exp;

    rst_n = 1'b0;
    bus.axi_awaddr_i = '0; bus.axi_awvalid_i = 1'b0;
    bus.axi_wdata_i = '0; bus.axi_wstrb_i = '0; bus.axi_wvalid_i = 1'b0;
    bus.axi_bready_i = 1'b1;
    bus.axi_araddr_i = '0; bus.axi_arvalid_i = 1'b0;
    bus.axi_rready_i = 1'b1;

    // Reset state
    tk();
    chk("rst_awready", 64'(bus.axi_awready_o), 64'h1);
    chk("rst_wready",  64'(bus.axi_wready_o),  64'h1);
    chk("rst_arready", 64'(bus.axi_arready_o), 64'h1);
    chk("rst_cyc",     64'(bus.wb_cyc_o),      64'h0);
    chk("rst_bvalid",  64'(bus.axi_bvalid_o),  64'h0);
    chk("rst_rvalid",  64'(bus.axi_rvalid_o),  64'h0);
    chk("rst_adr",     64'(bus.wb_adr_o),      64'h0);
    chk("rst_wbrst",   64'(wb_rst),            64'h1);
    rst_n = 1'b1;
    tk();
    chk("wbrst_rel",   64'(wb_rst),            64'h0);

    // Write then write: AW two cycles before W, second request during cycle
    p0 = pulses;
    bus.axi_awaddr_i = 32'h10; bus.axi_awvalid_i = 1'b1;
    tk();
    bus.axi_awvalid_i = 1'b0;
    chk("t1_aw_full", 64'(bus.axi_awready_o), 64'h0);
    tk();
    bus.axi_wdata_i = 32'hDEADBEEF; bus.axi_wstrb_i = 4'hF; bus.axi_wvalid_i = 1'b1;
    tk();
    bus.axi_wvalid_i = 1'b0;
    chk("t1_no_launch", 64'(bus.wb_stb_o), 64'h0);
    tk();
    chk("t1_stb", 64'(bus.wb_cyc_o & bus.wb_stb_o), 64'h1);
    chk("t1_we",  64'(bus.wb_we_o), 64'h1);
    chk("t1_adr", 64'(bus.wb_adr_o), 64'h10);
    chk("t1_sel", 64'(bus.wb_sel_o), 64'hF);
    chk("t1_dat", 64'(bus.wb_dat_o), 64'hDEADBEEF);
    chk("t1_freed", 64'(bus.axi_awready_o & bus.axi_wready_o), 64'h1);
    bus.axi_awaddr_i = 32'h1E; bus.axi_wdata_i = 32'hCAFEF00D; bus.axi_wstrb_i = 4'h3;
    bus.axi_awvalid_i = 1'b1; bus.axi_wvalid_i = 1'b1;
    tk();
    bus.axi_awvalid_i = 1'b0; bus.axi_wvalid_i = 1'b0;
    chk("t1_bvalid", 64'(bus.axi_bvalid_o), 64'h1);
    chk("t1_bresp",  64'(bus.axi_bresp_o),  64'h0);
    chk("t1_stb_dn", 64'(bus.wb_stb_o),     64'h0);
    tk();
    chk("t1_bdone",  64'(bus.axi_bvalid_o | bus.wb_stb_o), 64'h0);
    tk();
    chk("t1_2_stb", 64'(bus.wb_stb_o), 64'h1);
    chk("t1_2_adr", 64'(bus.wb_adr_o), 64'h1C);
    chk("t1_2_sel", 64'(bus.wb_sel_o), 64'h3);
    chk("t1_2_dat", 64'(bus.wb_dat_o), 64'hCAFEF00D);
    tk();
    chk("t1_2_bvalid", 64'(bus.axi_bvalid_o), 64'h1);
    chk("t1_pulses", 64'(pulses - p0), 64'h2);
    tk();

    // Read with 3 wait states, rready held low for 4 cycles
    sl_wait = 3; sl_rdata = 32'h12345678;
    bus.axi_rready_i = 1'b0;
    issue_rd(32'h24);
    tk();
    chk("t2_stb", 64'(bus.wb_stb_o), 64'h1);
    chk("t2_we",  64'(bus.wb_we_o),  64'h0);
    chk("t2_adr", 64'(bus.wb_adr_o), 64'h24);
    chk("t2_sel", 64'(bus.wb_sel_o), 64'hF);
    n = 0;
    while (!bus.axi_rvalid_o && n < 20) begin tk(); n++; end
    chk("t2_lat", 64'(n), 64'h4);
    chk("t2_rdata", 64'(bus.axi_rdata_o), 64'h12345678);
    chk("t2_rresp", 64'(bus.axi_rresp_o), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tk();
      chk("t2_hold_rvalid", 64'(bus.axi_rvalid_o), 64'h1);
      chk("t2_hold_rdata",  64'(bus.axi_rdata_o),  64'h12345678);
    end
    bus.axi_rready_i = 1'b1;
    tk();
    chk("t2_rdone", 64'(bus.axi_rvalid_o), 64'h0);
    sl_wait = 0;

    // Both pending at IDLE from reset: launches alternate W,R,W,R
    do_reset();
    ord_exp = 4'b0101;
    bus.axi_awaddr_i = 32'h100; bus.axi_wdata_i = 32'h1; bus.axi_wstrb_i = 4'hF;
    bus.axi_araddr_i = 32'h200;
    bus.axi_awvalid_i = 1'b1; bus.axi_wvalid_i = 1'b1; bus.axi_arvalid_i = 1'b1;
    tk();
    bus.axi_awvalid_i = 1'b0; bus.axi_wvalid_i = 1'b0; bus.axi_arvalid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.wb_stb_o && n < 40) begin tk(); n++; end
      chk("t3_stb",   64'(bus.wb_stb_o), 64'h1);
      chk("t3_order", 64'(bus.wb_we_o), 64'(ord_exp[k]));
      chk("t3_adr",   64'(bus.wb_adr_o), ord_exp[k] ? 64'h100 : 64'h200);
      if (bus.wb_we_o) begin
        bus.axi_awvalid_i = 1'b1; bus.axi_wvalid_i = 1'b1;
      end else begin
        bus.axi_arvalid_i = 1'b1;
      end
      tk();
      bus.axi_awvalid_i = 1'b0; bus.axi_wvalid_i = 1'b0; bus.axi_arvalid_i = 1'b0;
    end
    do_reset();

    // Retry: 3 rty then ack -> 4 pulses with single-cycle gaps, OKAY
    sl_rty_n = 3; sl_final = 0;
    p0 = pulses;
    issue_wr(32'h40, 32'h55, 4'hF);
    tk();
    h[0] = bus.wb_stb_o;
    for (int i = 1; i < 8; i++) begin tk(); h[i] = bus.wb_stb_o; end
    chk("t4a_pattern", 64'(h), 64'h55);
    chk("t4a_bvalid",  64'(bus.axi_bvalid_o), 64'h1);
    chk("t4a_bresp",   64'(bus.axi_bresp_o),  64'h0);
    chk("t4a_pulses",  64'(pulses - p0), 64'h4);
    tk();

    // Retry exhausted: 4 rty -> 4 pulses, SLVERR, rdata 0
    sl_rty_n = 4;
    p0 = pulses;
    issue_rd(32'h44);
    tk();
    h[0] = bus.wb_stb_o;
    for (int i = 1; i < 8; i++) begin tk(); h[i] = bus.wb_stb_o; end
    chk("t4b_pattern", 64'(h), 64'h55);
    chk("t4b_rvalid",  64'(bus.axi_rvalid_o), 64'h1);
    chk("t4b_rresp",   64'(bus.axi_rresp_o),  64'h2);
    chk("t4b_rdata",   64'(bus.axi_rdata_o),  64'h0);
    chk("t4b_pulses",  64'(pulses - p0), 64'h4);
    tk();
    sl_rty_n = 0;

    // Slave error on write -> SLVERR
    sl_final = 1;
    issue_wr(32'h60, 32'hA5A5A5A5, 4'hF);
    tk();
    chk("t5_stb", 64'(bus.wb_stb_o), 64'h1);
    tk();
    chk("t5_bvalid", 64'(bus.axi_bvalid_o), 64'h1);
    chk("t5_bresp",  64'(bus.axi_bresp_o),  64'h2);
    tk();

    // No slave answer on read -> stb high 8 cycles, DECERR, rdata 0
    sl_final = 2;
    issue_rd(32'h80);
    tk();
    n = 0;
    while (bus.wb_stb_o && n < 30) begin tk(); n++; end
    chk("t5_tmo_len", 64'(n), 64'h8);
    chk("t5_rvalid",  64'(bus.axi_rvalid_o), 64'h1);
    chk("t5_rresp",   64'(bus.axi_rresp_o),  64'h3);
    chk("t5_rdata",   64'(bus.axi_rdata_o),  64'h0);
    tk();

    // Asynchronous reset in the middle of a hung write cycle
    issue_wr(32'h70, 32'h77, 4'hF);
    tk();
    chk("t6_stb_pre", 64'(bus.wb_stb_o), 64'h1);
    #3;
    rst_n = 1'b0;
    #2;
    chk("t6_cyc_async", 64'(bus.wb_cyc_o), 64'h0);
    chk("t6_stb_async", 64'(bus.wb_stb_o), 64'h0);
    chk("t6_wbrst",     64'(wb_rst),       64'h1);
    tk();
    rst_n = 1'b1;
    tk();
    chk("t6_readys", 64'({bus.axi_awready_o, bus.axi_wready_o, bus.axi_arready_o}), 64'h7);
    chk("t6_valids", 64'({bus.axi_bvalid_o, bus.axi_rvalid_o}), 64'h0);
    repeat (3) tk();
    chk("t6_quiet", 64'({bus.axi_bvalid_o, bus.axi_rvalid_o, bus.wb_stb_o}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
